// File: rtl/gpio_wb_ctrl.sv
// gpio_wb_ctrl: Wishbone GPIO block. It has an output register with set and
// clear aliases, a synchronised input port, per-bit edge detection into a
// sticky W1C status register, and one registered level interrupt.
module gpio_wb_ctrl #(
  parameter int          IN_W        = 16,
  parameter int          OUT_W       = 32,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] OUT_RESET   = 32'h0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb_cyc_i,
  input  logic             wb_stb_i,
  input  logic             wb_we_i,
  input  logic [4:0]       wb_adr_i,
  input  logic [3:0]       wb_sel_i,
  input  logic [31:0]      wb_dat_i,
  output logic [31:0]      wb_dat_o,
  output logic             wb_ack_o,
  input  logic [IN_W-1:0]  gpio_i,
  output logic [OUT_W-1:0] gpio_o,
  output logic             irq_o
);

  // Word offsets of the register map (byte address bits [4:2]).
  typedef enum logic [2:0] {
    A_OUT  = 3'd0,
    A_IN   = 3'd1,
    A_EN   = 3'd2,
    A_MODE = 3'd3,
    A_STAT = 3'd4,
    A_SET  = 3'd5,
    A_CLR  = 3'd6
  } reg_addr_e;

  // The arm counter must hold SYNC_STAGES+1, which is at most 5.
  localparam int             ARM_W    = 3;
  localparam logic [ARM_W-1:0] ARM_LOAD = ARM_W'(SYNC_STAGES + 1);

  logic [OUT_W-1:0]                  out_q,  out_d;
  logic [IN_W-1:0]                   en_q,   en_d;
  logic [IN_W-1:0]                   mode_q, mode_d;
  logic [IN_W-1:0]                   stat_q, stat_d;
  logic [SYNC_STAGES-1:0][IN_W-1:0]  sync_q, sync_d;
  logic [IN_W-1:0]                   prev_q, prev_d;
  logic [ARM_W-1:0]                  arm_q,  arm_d;
  logic                              ack_q,  ack_d;
  logic                              irq_q,  irq_d;
  logic [31:0]                       dat_q,  dat_d;

  logic            req;
  logic            wr;
  reg_addr_e       addr;
  logic [31:0]     wmask;
  logic [31:0]     wdat;
  logic [31:0]     rdata;
  logic [IN_W-1:0] sync_last;
  logic [IN_W-1:0] evt;
  logic [IN_W-1:0] w1c;
  logic            unused_adr;

  // A held strobe is only accepted while no ack is out, so acks never repeat
  // on consecutive cycles.
  assign req       = wb_cyc_i & wb_stb_i & ~ack_q;
  assign wr        = req & wb_we_i;
  assign addr      = reg_addr_e'(wb_adr_i[4:2]);
  assign wmask     = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}},
                      {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
  assign wdat      = wb_dat_i & wmask;
  assign sync_last = sync_q[SYNC_STAGES-1];
  assign unused_adr = ^wb_adr_i[1:0];

  // Edge detect with the mode that is in effect before this cycle's write.
  assign evt = (mode_q & prev_q & ~sync_last) | (~mode_q & sync_last & ~prev_q);

  // Read mux; unmapped and write-only offsets return 0.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would infer a latch.
    rdata = '0;
    case (addr)
      A_OUT:   rdata[OUT_W-1:0] = out_q;
      A_IN:    rdata[IN_W-1:0]  = sync_last;
      A_EN:    rdata[IN_W-1:0]  = en_q;
      A_MODE:  rdata[IN_W-1:0]  = mode_q;
      A_STAT:  rdata[IN_W-1:0]  = stat_q;
      default: rdata = '0;
    endcase
  end

  // Next-state logic for registers, status, synchroniser and bus response.
  always_comb begin
    out_d  = out_q;
    en_d   = en_q;
    mode_d = mode_q;
    w1c    = '0;
    if (wr) begin
      case (addr)
        A_OUT:  out_d  = (out_q & ~wmask[OUT_W-1:0]) | wdat[OUT_W-1:0];
        A_EN:   en_d   = (en_q & ~wmask[IN_W-1:0]) | wdat[IN_W-1:0];
        A_MODE: mode_d = (mode_q & ~wmask[IN_W-1:0]) | wdat[IN_W-1:0];
        A_STAT: w1c    = wdat[IN_W-1:0];
        A_SET:  out_d  = out_q | wdat[OUT_W-1:0];
        A_CLR:  out_d  = out_q & ~wdat[OUT_W-1:0];
        default: ;
      endcase
    end

    // Set beats clear when an event and a W1C hit the same bit together.
    stat_d = (stat_q & ~w1c) | ((arm_q == '0) ? evt : '0);
    arm_d  = (arm_q == '0) ? '0 : arm_q - ARM_W'(1);

    sync_d = {sync_q[SYNC_STAGES-2:0], gpio_i};
    prev_d = sync_last;

    irq_d  = |(stat_q & en_q);
    ack_d  = req;
    dat_d  = (req & ~wb_we_i) ? rdata : 32'h0;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      out_q  <= OUT_RESET[OUT_W-1:0];
      en_q   <= '0;
      mode_q <= '0;
      stat_q <= '0;
      // NOTE: the synchroniser is an ordinary flop chain, not a memory, so it
      // is reset to give the arm window a known starting point.
      sync_q <= '0;
      prev_q <= '0;
      arm_q  <= ARM_LOAD;
      ack_q  <= 1'b0;
      irq_q  <= 1'b0;
      dat_q  <= '0;
    end else begin
      out_q  <= out_d;
      en_q   <= en_d;
      mode_q <= mode_d;
      stat_q <= stat_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
      arm_q  <= arm_d;
      ack_q  <= ack_d;
      irq_q  <= irq_d;
      dat_q  <= dat_d;
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign gpio_o   = out_q;
  assign irq_o    = irq_q;

endmodule
